// File: rtl/kpscan_pkg.sv
// rtl/kpscan_pkg.sv - shared state encoding, column drive patterns and defaults
// for the keypad scan controller.
package kpscan_pkg;

   localparam int SETTLE_CYC_DEF   = 16;
   localparam int DEBOUNCE_CNT_DEF = 4;

   localparam logic [3:0] COL_0 = 4'b0111;
   localparam logic [3:0] COL_1 = 4'b1011;
   localparam logic [3:0] COL_2 = 4'b1101;
   localparam logic [3:0] COL_3 = 4'b1110;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   // Rotating the single low bit right walks COL_0 -> COL_3 and wraps.
   function automatic logic [3:0] next_col(input logic [3:0] col);
      return {col[0], col[3:1]};
   endfunction

endpackage

// File: rtl/kp_keymap.sv
// rtl/kp_keymap.sv - combinational decode of column drive plus row pattern
// into the printed button value.
module kp_keymap
   import kpscan_pkg::*;
(
   input  logic [3:0] i_col,
   input  logic [3:0] i_row,
   output logic [3:0] o_code
);

   always_comb begin
      o_code = 4'd0;
      case (i_col)
         COL_0:
            case (i_row)
               4'b0111: o_code = 4'd1;
               4'b1011: o_code = 4'd4;
               4'b1101: o_code = 4'd7;
               4'b1110: o_code = 4'd14;
               default: o_code = 4'd0;
            endcase
         COL_1:
            case (i_row)
               4'b0111: o_code = 4'd2;
               4'b1011: o_code = 4'd5;
               4'b1101: o_code = 4'd8;
               4'b1110: o_code = 4'd0;
               default: o_code = 4'd0;
            endcase
         COL_2:
            case (i_row)
               4'b0111: o_code = 4'd3;
               4'b1011: o_code = 4'd6;
               4'b1101: o_code = 4'd9;
               4'b1110: o_code = 4'd15;
               default: o_code = 4'd0;
            endcase
         COL_3:
            case (i_row)
               4'b0111: o_code = 4'd10;
               4'b1011: o_code = 4'd11;
               4'b1101: o_code = 4'd12;
               4'b1110: o_code = 4'd13;
               default: o_code = 4'd0;
            endcase
         default: o_code = 4'd0;
      endcase
   end

endmodule

// File: rtl/kpscan_ctrl.sv
// rtl/kpscan_ctrl.sv - 4x4 keypad scanner with debounce, ghost rejection and
// a single-entry event register with overrun indication.
module kpscan_ctrl
   import kpscan_pkg::*;
#(
   parameter int SETTLE_CYC   = SETTLE_CYC_DEF,
   parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] kpr,
   output logic [3:0] kpc,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overrun
);

   localparam int WIN_W = $clog2(SETTLE_CYC);
   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit   ONE_SHOT = (DEBOUNCE_CNT == 1);

   logic [3:0]       r_sync1, r_sync2, r_pat, r_kpc, r_code;
   logic [WIN_W-1:0] r_win;
   logic [CNT_W-1:0] r_cnt;
   state_t           r_state;
   logic             r_valid, r_overrun;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt, w_cnt_inc;
   logic [3:0]       w_kpc_nxt, w_pat_nxt, w_key;
   logic             w_sample, w_all_high, w_one_low, w_event, w_load;

   kp_keymap u_keymap (
      .i_col  (r_kpc),
      .i_row  (r_sync2),
      .o_code (w_key)
   );

   assign w_sample   = (r_win == WIN_LAST);
   assign w_all_high = (r_sync2 == 4'hF);
   assign w_one_low  = (r_sync2 == 4'b0111) || (r_sync2 == 4'b1011) ||
                       (r_sync2 == 4'b1101) || (r_sync2 == 4'b1110);
   assign w_cnt_inc  = r_cnt + CNT_ONE;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_kpc_nxt   = r_kpc;
      w_pat_nxt   = r_pat;
      w_event     = 1'b0;
      if (w_sample) begin
         case (r_state)
            ST_SCAN:
               if (w_one_low) begin
                  w_pat_nxt   = r_sync2;
                  w_cnt_nxt   = CNT_ONE;
                  w_state_nxt = ST_DEBOUNCE;
                  if (ONE_SHOT) begin
                     w_state_nxt = ST_HELD;
                     w_cnt_nxt   = '0;
                     w_event     = 1'b1;
                  end
               end else begin
                  w_kpc_nxt = next_col(r_kpc);
               end
            ST_DEBOUNCE:
               if (r_sync2 == r_pat) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == CNT_DONE) begin
                     w_state_nxt = ST_HELD;
                     w_cnt_nxt   = '0;
                     w_event     = 1'b1;
                  end
               end else begin
                  w_state_nxt = ST_SCAN;
                  w_cnt_nxt   = '0;
                  w_kpc_nxt   = next_col(r_kpc);
               end
            ST_HELD:
               if (w_all_high) begin
                  w_state_nxt = ST_RELEASE;
                  w_cnt_nxt   = CNT_ONE;
                  if (ONE_SHOT) begin
                     w_state_nxt = ST_SCAN;
                     w_cnt_nxt   = '0;
                     w_kpc_nxt   = next_col(r_kpc);
                  end
               end
            ST_RELEASE:
               if (w_all_high) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == CNT_DONE) begin
                     w_state_nxt = ST_SCAN;
                     w_cnt_nxt   = '0;
                     w_kpc_nxt   = next_col(r_kpc);
                  end
               end else begin
                  w_state_nxt = ST_HELD;
                  w_cnt_nxt   = '0;
               end
            default: w_state_nxt = ST_SCAN;
         endcase
      end
   end

   // A consumer handshake in the same cycle frees the slot for the new event.
   assign w_load = w_event && (!r_valid || key_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1   <= 4'hF;
         r_sync2   <= 4'hF;
         r_win     <= '0;
         r_cnt     <= '0;
         r_state   <= ST_SCAN;
         r_pat     <= 4'hF;
         r_kpc     <= COL_0;
         r_code    <= 4'd0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_sync1   <= kpr;
         r_sync2   <= r_sync1;
         r_win     <= w_sample ? '0 : r_win + WIN_W'(1);
         r_cnt     <= w_cnt_nxt;
         r_state   <= w_state_nxt;
         r_pat     <= w_pat_nxt;
         r_kpc     <= w_kpc_nxt;
         r_valid   <= w_load || (r_valid && !key_ready);
         r_overrun <= w_event && !w_load;
         if (w_load) begin
            r_code <= w_key;
         end
      end
   end

   assign kpc       = r_kpc;
   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign key_held  = (r_state == ST_HELD) || (r_state == ST_RELEASE);
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_kpscan_ctrl.sv
// tb/tb_kpscan_ctrl.sv - directed bench for kpscan_ctrl with SETTLE_CYC=4,
// DEBOUNCE_CNT=3 and a single-key keypad model driving the rows.
module tb_kpscan_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] kpr;
   logic [3:0] kpc;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       key_held;
   logic       overrun;

   logic       pressed;
   logic [3:0] key_col;
   logic [3:0] key_row;

   int n_assert = 0;
   int n_fail   = 0;
   int vcnt     = 0;
   int ocnt     = 0;
   int v0, o0;

   logic [3:0] colseq [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   kpscan_ctrl #(.SETTLE_CYC(4), .DEBOUNCE_CNT(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .kpr       (kpr),
      .kpc       (kpc),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_held  (key_held),
      .overrun   (overrun)
   );

   // A pressed key pulls its row(s) low only while its column is driven.
   assign kpr = (pressed && kpc == key_col) ? key_row : 4'hF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_valid) vcnt++;
      if (overrun)   ocnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic win(input int n);
      repeat (4 * n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset     = 1'b1;
      key_ready = 1'b1;
      pressed   = 1'b0;
      key_col   = 4'b0111;
      key_row   = 4'hF;
      tick(3);
      chk("rst_kpc", kpc, 4'b0111);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_code", key_code, 4'd0);
      chk("rst_held", key_held, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      reset = 1'b0;

      // Idle rotation, one window per column
      for (int w = 0; w < 8; w++) begin
         chk("idle_kpc", kpc, colseq[w % 4]);
         chk("idle_valid", key_valid, 1'b0);
         tick(3);
         chk("idle_kpc_hold", kpc, colseq[w % 4]);
         tick(1);
      end

      // Key 8: column 1011, row 1101
      v0 = vcnt;
      key_col = 4'b1011; key_row = 4'b1101; pressed = 1'b1;
      win(2);
      chk("k8_frozen", kpc, 4'b1011);
      chk("k8_deb_held", key_held, 1'b0);
      win(2);
      chk("k8_valid", key_valid, 1'b1);
      chk("k8_code", key_code, 4'd8);
      chk("k8_held", key_held, 1'b1);
      tick(1);
      chk("k8_valid_clr", key_valid, 1'b0);
      chk("k8_held2", key_held, 1'b1);
      tick(3);
      pressed = 1'b0;
      win(2);
      chk("k8_rel_held", key_held, 1'b1);
      win(1);
      chk("k8_released", key_held, 1'b0);
      chk("k8_next_col", kpc, 4'b1101);
      chk("k8_one_event", vcnt - v0, 1);

      // Key 10 with a one-sample bounce mid-debounce
      v0 = vcnt;
      key_col = 4'b1110; key_row = 4'b0111; pressed = 1'b1;
      win(3);
      chk("b10_frozen", kpc, 4'b1110);
      pressed = 1'b0;
      win(1);
      chk("b10_rescan", kpc, 4'b0111);
      chk("b10_no_early", key_valid, 1'b0);
      pressed = 1'b1;
      win(6);
      chk("b10_valid", key_valid, 1'b1);
      chk("b10_code", key_code, 4'd10);
      tick(4);
      chk("b10_one_event", vcnt - v0, 1);
      pressed = 1'b0;
      win(3);
      chk("b10_released", key_held, 1'b0);
      chk("b10_next_col", kpc, 4'b0111);

      // Ghost: two rows low on column 0111
      v0 = vcnt;
      key_col = 4'b0111; key_row = 4'b1001; pressed = 1'b1;
      win(1);
      chk("ghost_adv", kpc, 4'b1011);
      chk("ghost_held", key_held, 1'b0);
      win(3);
      chk("ghost_wrap", kpc, 4'b0111);
      win(1);
      chk("ghost_adv2", kpc, 4'b1011);
      chk("ghost_no_event", vcnt - v0, 0);

      // Consumer stalled: 5 is kept, 9 is dropped with one overrun pulse
      o0 = ocnt;
      key_ready = 1'b0;
      key_col = 4'b1011; key_row = 4'b1011;
      win(3);
      chk("ov_valid5", key_valid, 1'b1);
      chk("ov_code5", key_code, 4'd5);
      pressed = 1'b0;
      win(3);
      chk("ov_col", kpc, 4'b1101);
      chk("ov_still_valid", key_valid, 1'b1);
      key_col = 4'b1101; key_row = 4'b1101; pressed = 1'b1;
      win(3);
      chk("ov_pulse", overrun, 1'b1);
      chk("ov_code_kept", key_code, 4'd5);
      chk("ov_valid_kept", key_valid, 1'b1);
      chk("ov_held9", key_held, 1'b1);
      tick(1);
      chk("ov_pulse_end", overrun, 1'b0);
      key_ready = 1'b1;
      tick(1);
      chk("ov_cleared", key_valid, 1'b0);
      tick(2);
      pressed = 1'b0;
      win(3);
      chk("ov_next_col", kpc, 4'b1110);
      chk("ov_released", key_held, 1'b0);
      chk("ov_count", ocnt - o0, 1);

      // Reset in the middle of a debounce
      key_col = 4'b1110; key_row = 4'b1101; pressed = 1'b1;
      win(2);
      chk("rd_frozen", kpc, 4'b1110);
      chk("rd_deb_held", key_held, 1'b0);
      reset = 1'b1;
      #1;
      chk("rd_kpc", kpc, 4'b0111);
      chk("rd_code", key_code, 4'd0);
      chk("rd_valid", key_valid, 1'b0);
      chk("rd_held", key_held, 1'b0);
      chk("rd_overrun", overrun, 1'b0);
      tick(3);
      key_ready = 1'b0;
      reset = 1'b0;
      win(5);
      chk("rd_no_early", key_valid, 1'b0);
      chk("rd_col", kpc, 4'b1110);
      win(1);
      chk("rd_valid12", key_valid, 1'b1);
      chk("rd_code12", key_code, 4'd12);

      // Reset with an event pending
      tick(1);
      reset = 1'b1;
      #1;
      chk("rv_valid", key_valid, 1'b0);
      chk("rv_code", key_code, 4'd0);
      chk("rv_held", key_held, 1'b0);
      chk("rv_kpc", kpc, 4'b0111);
      pressed   = 1'b0;
      key_ready = 1'b1;
      tick(2);
      reset = 1'b0;
      v0 = vcnt;
      win(8);
      chk("rv_no_event", vcnt - v0, 0);
      chk("rv_valid_end", key_valid, 1'b0);
      chk("rv_held_end", key_held, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/kpscan_ctrl.md
KPSCAN_CTRL -- requirements
Module: kpscan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 16: clocks each column is driven before the rows are sampled (minimum 2).
REQ-002 Parameter DEBOUNCE_CNT, default 4: number of consecutive identical samples required to accept a press or a release (minimum 1).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port kpr, input, 4 bits: keypad rows, active-low, asynchronous to clk.
REQ-006 Port kpc, output, 4 bits: keypad column drive, active-low, exactly one bit low at any time.
REQ-007 Port key_code, output, 4 bits: decoded button value of the pending event.
REQ-008 Port key_valid, output, 1 bit: a key event is pending on key_code.
REQ-009 Port key_ready, input, 1 bit: the consumer accepts the event.
REQ-010 Port key_held, output, 1 bit: a debounced key is currently down.
REQ-011 Port overrun, output, 1 bit: one-cycle pulse when an event is dropped.

Function
REQ-012 kpr SHALL pass through a 2-flop synchronizer; every sample is taken from the synchronized value.
REQ-013 Column sequence SHALL be 4'b0111, 4'b1011, 4'b1101, 4'b1110, then wrap to 4'b0111, each driven for SETTLE_CYC cycles.
REQ-014 The sample SHALL be taken in the last cycle of each SETTLE_CYC window.
REQ-015 Decode, by column then rows 0111/1011/1101/1110: col 0111 -> 1,4,7,14; col 1011 -> 2,5,8,0; col 1101 -> 3,6,9,15; col 1110 -> 10,11,12,13.
REQ-016 States SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-017 SCAN: rotate columns; a sample with exactly one row low SHALL freeze the column, latch the row pattern and go to DEBOUNCE with count=1.
REQ-018 SCAN: a sample with all rows high, or with two or more rows low (ghost), SHALL advance to the next column.
REQ-019 DEBOUNCE: each sample equal to the latched pattern SHALL increment the count.
REQ-020 DEBOUNCE: any differing sample SHALL return to SCAN at the next column.
REQ-021 When the count reaches DEBOUNCE_CNT, the controller SHALL enter HELD and generate the event in the same cycle.
REQ-022 Event generation: if key_valid is low or key_ready is high that cycle, key_code and key_valid SHALL load on the next edge; otherwise the event SHALL be dropped, the old key_code kept and overrun pulsed.
REQ-023 key_valid SHALL stay high with key_code stable until a cycle with key_valid and key_ready both high, then clear on the next edge.
REQ-024 Load and clear in the same cycle SHALL result in the new event being held (key_valid stays 1).
REQ-025 key_held SHALL be 1 in HELD and RELEASE, 0 otherwise.
REQ-026 HELD: the column SHALL stay frozen; the first all-high sample SHALL enter RELEASE with count=1.
REQ-027 RELEASE: each all-high sample SHALL increment the count; any other sample SHALL return to HELD.
REQ-028 When the RELEASE count reaches DEBOUNCE_CNT, the controller SHALL return to SCAN at the next column.
REQ-029 Auto-repeat SHALL NOT be generated; one press produces exactly one event.

Reset
REQ-030 On reset: state SCAN, kpc 4'b0111, window counter 0, debounce count 0, synchronizer flops 4'hF.
REQ-031 On reset: key_code 0, key_valid 0, key_held 0, overrun 0.
REQ-032 Reset asserted mid-debounce or with an event pending SHALL discard all state; no event is emitted after reset release until a full new debounce completes.

Structure
REQ-033 Package kpscan_pkg SHALL hold the state enum, the column constants and the default parameter values.
REQ-034 Decode (column plus rows to 4-bit value) SHALL be a combinational sub-module kp_keymap, instantiated once.

Verification (SETTLE_CYC=4, DEBOUNCE_CNT=3, key_ready held 1 unless stated)
REQ-035 Idle, rows 4'hF: kpc cycles 0111->1011->1101->1110->0111 every 4 clocks; key_valid stays 0.
REQ-036 Hold row 1101 while kpc=1011 for 3 samples: one key_code=8 with key_valid for 1 cycle; key_held=1 until 3 all-high samples.
REQ-037 Bounce: row 0111 on col 1110 for 2 samples, 1 high sample, then stable for 3 samples: exactly one event, key_code=10.
REQ-038 Ghost: rows 1001 on col 0111: no event and the scan continues.
REQ-039 key_ready=0: press 5 then, after release, 9: key_code stays 5, overrun pulses once; raise key_ready: key_valid clears.
REQ-040 Assert reset during DEBOUNCE and with key_valid=1: all outputs at reset values, kpc=0111, no spurious event after release.
